// File: rtl/enc_parity_pkg.sv
// Shared types and elaboration-time helpers for the streaming Hamming parity encoder.
// Optional SEC-DED overall parity bit is enabled by defining ENC_PARITY_DED_EN.
package enc_parity_pkg;

`ifdef ENC_PARITY_DED_EN
    localparam int unsigned DED_W = 1;
`else
    localparam int unsigned DED_W = 0;
`endif

    typedef enum logic [0:0] {
        ACC = 1'b0,
        OUT = 1'b1
    } enc_state_t;

    // Smallest P with 2^P >= data_w + P + 1.
    function automatic int unsigned calc_p_w(input int unsigned data_w);
        int unsigned p;
        p = 0;
        for (int unsigned q = 1; q < 9; q++) begin
            if (p == 0 && (32'd1 << q) >= data_w + q + 1) p = q;
        end
        return p;
    endfunction

    // Codeword position of data bit i: the (i+1)-th non-power-of-two position.
    // Each power of two at or below the candidate position pushes it up by one.
    function automatic int unsigned data_pos(input int unsigned i);
        int unsigned skip;
        skip = 0;
        for (int unsigned q = 0; q < 9; q++) begin
            if ((32'd1 << q) <= i + 1 + skip) skip++;
        end
        return i + 1 + skip;
    endfunction

    // Data bits that feed Hamming parity bit k.
    function automatic logic [127:0] par_mask(input int unsigned data_w, input int unsigned k);
        logic [127:0] m;
        m = '0;
        for (int unsigned i = 0; i < 128; i++) begin
            if (i < data_w && ((data_pos(i) >> k) & 32'd1) != 32'd0) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Data bits that feed the overall parity: a data bit appears once itself plus once in
    // every parity bit its position selects, so it survives when that popcount is even.
    function automatic logic [127:0] ded_mask(input int unsigned data_w);
        logic [127:0] m;
        int unsigned  pos;
        int unsigned  ones;
        m = '0;
        for (int unsigned i = 0; i < 128; i++) begin
            if (i < data_w) begin
                pos  = data_pos(i);
                ones = 0;
                for (int unsigned b = 0; b < 9; b++) ones += (pos >> b) & 32'd1;
                if ((ones & 32'd1) == 32'd0) m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/enc_parity_chunk.sv
// Combinational partial parity of one chunk placed at offset beat*CHUNK_W of the word.
// Under ENC_PARITY_DED_EN the MSB carries the chunk's share of the overall parity.
module enc_parity_chunk
    import enc_parity_pkg::*;
#(
    parameter int unsigned  CHUNK_W   = 8,
    parameter int unsigned  NUM_BEATS = 4,
    localparam int unsigned DATA_W    = CHUNK_W * NUM_BEATS,
    localparam int unsigned P_W       = calc_p_w(DATA_W),
    localparam int unsigned OUT_W     = P_W + DED_W,
    localparam int unsigned CNT_W     = $clog2(NUM_BEATS + 1)
) (
    input  logic [CNT_W-1:0]   beat,
    input  logic [CHUNK_W-1:0] chunk,
    output logic [OUT_W-1:0]   part
);

    logic [NUM_BEATS-1:0][OUT_W-1:0] beat_part;

    for (genvar k = 0; k < P_W; k++) begin : g_par
        localparam logic [127:0] Mask = par_mask(DATA_W, k);
        for (genvar b = 0; b < NUM_BEATS; b++) begin : g_beat
            assign beat_part[b][k] = ^(chunk & Mask[b*CHUNK_W +: CHUNK_W]);
        end
    end

`ifdef ENC_PARITY_DED_EN
    localparam logic [127:0] DedMask = ded_mask(DATA_W);
    for (genvar b = 0; b < NUM_BEATS; b++) begin : g_ded
        assign beat_part[b][P_W] = ^(chunk & DedMask[b*CHUNK_W +: CHUNK_W]);
    end
`endif

    // Select the contribution for the beat currently being accepted.
    always_comb begin
        part = '0;
        for (int unsigned b = 0; b < NUM_BEATS; b++) begin
            if (beat == CNT_W'(b)) part = beat_part[b];
        end
    end

endmodule

// File: rtl/enc_parity_acc.sv
// Streaming Hamming parity encoder: folds NUM_BEATS chunks into one parity vector and
// presents it on a valid/ready output. Define ENC_PARITY_DED_EN for the SEC-DED overall bit.
module enc_parity_acc
    import enc_parity_pkg::*;
#(
    parameter int unsigned  CHUNK_W   = 8,
    parameter int unsigned  NUM_BEATS = 4,
    localparam int unsigned DATA_W    = CHUNK_W * NUM_BEATS,
    localparam int unsigned P_W       = calc_p_w(DATA_W),
    localparam int unsigned OUT_W     = P_W + DED_W,
    localparam int unsigned CNT_W     = $clog2(NUM_BEATS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [CHUNK_W-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [OUT_W-1:0]   m_parity,
    output logic [CNT_W-1:0]   m_beats
);

    enc_state_t       state_q, state_d;
    logic [OUT_W-1:0] acc_q, par_q, part, acc_next;
    logic [CNT_W-1:0] cnt_q;
    logic             en_q;
    logic             beat_take, last_beat, en_word;

    enc_parity_chunk #(
        .CHUNK_W  (CHUNK_W),
        .NUM_BEATS(NUM_BEATS)
    ) u_chunk (
        .beat (cnt_q),
        .chunk(s_data),
        .part (part)
    );

    // clr outranks a same-cycle beat while collecting.
    assign beat_take = (state_q == ACC) && s_valid && !clr;
    assign last_beat = (cnt_q == CNT_W'(NUM_BEATS - 1));
    // On beat 0 the live en decides; later beats use the latched value.
    assign en_word   = (cnt_q == '0) ? en : en_q;
    assign acc_next  = acc_q ^ part;

    assign m_parity = par_q;
    assign m_beats  = cnt_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave ACC on the final beat, leave OUT on the output handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACC:     if (beat_take && last_beat) state_d = OUT;
            OUT:     if (m_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // Handshake outputs decoded from state; s_ready is held low while reset is asserted.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        unique case (state_q)
            ACC:     s_ready = !rst;
            OUT:     m_valid = 1'b1;
            default: s_ready = 1'b0;
        endcase
    end

    // Accumulator, beat counter, en latch and the registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            en_q  <= 1'b0;
            par_q <= '0;
        end else if (state_q == ACC) begin
            if (clr) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (s_valid) begin
                if (cnt_q == '0) en_q <= en;
                acc_q <= acc_next;
                if (last_beat) begin
                    cnt_q <= '0;
                    par_q <= en_word ? acc_next : '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end else if (m_ready) begin
            acc_q <= '0;
        end
    end

endmodule

// File: doc/enc_parity_acc.md
Name: enc_parity_acc

Overview:
Parametrised, streaming Hamming parity encoder. It is the successor to the fixed 16/32-bit cascaded parity encoders.
- Accepts a DATA_W-bit word as NUM_BEATS chunks of CHUNK_W bits over a valid/ready stream.
- Accumulates partial parity across beats, the same way the 32-bit encoder folds in the 16-bit parity.
- Emits the complete parity vector on an output handshake.
- Sits between the data source and the codeword assembler in the encoder datapath.

Parameters:
CHUNK_W, 8, data bits per input beat
NUM_BEATS, 4, beats per word; DATA_W = CHUNK_W*NUM_BEATS (legal DATA_W range 4..128)
P_W, derived localparam, smallest P with 2^P >= DATA_W+P+1 (DATA_W=16 gives 5; DATA_W=32 gives 6)
OUT_W, derived localparam, P_W, or P_W+1 when ENC_PARITY_DED_EN is defined

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  encoder enable; when low the word's parity is forced to zero
clr  in  1  synchronous abort; discards the partial word
s_valid  in  1  input beat valid
s_ready  out  1  input beat ready
s_data  in  CHUNK_W  input chunk; beat 0 carries data bits [CHUNK_W-1:0]
m_valid  out  1  parity valid
m_ready  in  1  parity consumed
m_parity  out  OUT_W  parity vector; bit k = Hamming parity k; MSB = overall parity under DED
m_beats  out  clog2(NUM_BEATS+1)  debug: beats accepted in the current word

Behaviour:
- Codeword mapping:
  - Positions 1..DATA_W+P_W.
  - Parity bits occupy power-of-two positions.
  - Data bit i occupies the (i+1)-th non-power-of-two position, ascending.
  - Example, DATA_W=32: bit0→3, bit1→5, bit3→7, bit4→9, bit11→17, bit26→33, bit31→38.
  - Parity k = XOR of all data bits whose position has bit k set.
- Per-beat update, on an accepted beat b:
  - acc ^= contribution of s_data placed at offset b*CHUNK_W.
  - The contribution is a combinational function of (b, s_data).
- States: ACC, OUT.
- ACC:
  - s_ready=1, m_valid=0.
  - On s_valid&&s_ready: update acc, increment beat counter.
  - When the accepted beat is beat NUM_BEATS-1: register the result, reset the counter, go to OUT.
  - Result = acc_next if en was sampled high on beat 0, else all zeros.
- OUT:
  - s_ready=0, m_valid=1, m_parity held stable.
  - On m_ready: clear acc, return to ACC.
  - Exactly one bubble cycle between words; no skid buffer.
- Latency: m_valid rises the cycle after the last beat is accepted.
- en is latched on beat 0 and held for the whole word; changes mid-word are ignored.
- clr:
  - In ACC: zero acc and counter, discard the word; this takes priority over a same-cycle beat.
  - In OUT: clr has no effect; an output that is already valid is never dropped.
- Backpressure: m_ready held low keeps OUT indefinitely, with m_parity unchanged.
- Reset (asynchronous, rst=1): state=ACC, acc=0, counter=0, en latch=0, m_valid=0, m_parity=0. s_ready=0 while rst is asserted, 1 the cycle after release.
- Counter wrap: the counter counts 0..NUM_BEATS-1 and never overflows.
- NUM_BEATS=1 degenerates to a one-beat word with the same handshake.

Optional Feature:
- Macro: ENC_PARITY_DED_EN.
- Defined:
  - OUT_W=P_W+1.
  - m_parity[P_W] = XOR of all data bits and all P_W parity bits (SEC-DED overall parity).
  - Accumulated per beat alongside acc.
  - Forced to 0 when en is low.
- Undefined: OUT_W=P_W; no overall-parity logic is generated.

Decomposition:
- Package enc_parity_pkg:
  - function calc_p_w(data_w);
  - function data_pos(i) returning the codeword position;
  - typedef enum {ACC, OUT} enc_state_t.
- Sub-module enc_parity_chunk:
  - Combinational.
  - Inputs: beat index and chunk. Output: P_W-bit partial parity (plus an overall bit under DED).
  - Instantiated once, muxed by the beat counter.

Test Plan:
- DATA_W=32 (8x4), en=1, all-zero word → m_parity=6'b000000, m_valid one cycle after beat 3.
- Single data bit 0 set (beat0=8'h01, rest 0) → 6'b000011. Under DED: 7'b1000011.
- Bits 0 and 31 set (beat0=8'h01, beat3=8'h80) → 6'b100101 (cross-beat XOR accumulation).
- en=0 on beat 0, then en=1 on later beats, with bit 1 set → parity 0. Next word with en=1 and bit 1 set → 6'b000101.
- clr asserted after beat 2, then a fresh word with bit 31 set → 6'b100110, with no residue from the aborted word.
- m_ready held low 5 cycles in OUT → m_valid stays 1, s_ready stays 0, parity unchanged. rst pulse mid-word → all outputs 0 immediately.
